// File: rtl/quad_step_decoder_pkg.sv
// Shared constants for the quadrature front end: direction encoding, Gray-code
// states and default filter timing.
package quad_step_decoder_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_LEN  = 4;

    // {a,b} as seen by the decoder.
    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_state_t;

    // Successor of a state when the shaft turns forward (00->01->11->10->00).
    function automatic quad_state_t fwd_next(input quad_state_t s);
        case (s)
            Q00:     return Q01;
            Q01:     return Q11;
            Q11:     return Q10;
            default: return Q00;
        endcase
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: metastability synchroniser followed by a persistence
// filter that accepts a new level only after FILTER_LEN consecutive edges.
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filtered,
    output logic busy
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;

    assign synced = sync_chain[SYNC_STAGES-1];
    assign busy   = (synced != filtered);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            cnt        <= '0;
            filtered   <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin};
            // Any edge where the levels agree restarts the persistence count.
            if (synced != filtered) begin
                if (cnt == CNT_LAST) begin
                    filtered <= synced;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: filtered A/B are decoded into a step pulse and
// direction; double-bit jumps raise a sticky error and a saturating counter.
module quad_step_decoder
    import quad_step_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int FL_W = $clog2(SYNC_STAGES + 1);

    logic        filt_a, filt_b, busy_a, busy_b;
    quad_state_t cur, prev;
    logic        init, changed, is_fwd, is_rev, illegal, settled, flushed;
    logic [FL_W-1:0] flush_cnt;

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .pin(enc_a), .filtered(filt_a), .busy(busy_a)
    );

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .pin(enc_b), .filtered(filt_b), .busy(busy_b)
    );

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cur     = quad_state_t'({filt_a, filt_b});
    assign changed = (cur != prev);
    assign is_fwd  = (fwd_next(prev) == cur);
    assign is_rev  = (fwd_next(cur) == prev);
    assign illegal = changed && !is_fwd && !is_rev && !init;
    assign flushed = (flush_cnt == FL_W'(SYNC_STAGES));
    // Pins have propagated through the chain and neither filter is mid-change.
    assign settled = flushed && !busy_a && !busy_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (!flushed) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // The resting position seen after reset is absorbed silently. An encoder
    // parked at 00 never produces a change, so init also retires once the
    // input path has settled with nothing to load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= Q00;
            init <= 1'b1;
            step <= 1'b0;
            dir  <= DIR_UP;
        end else begin
            prev <= cur;
            step <= 1'b0;
            if (init) begin
                if (changed || settled)
                    init <= 1'b0;
            end else if (is_fwd) begin
                step <= 1'b1;
                dir  <= DIR_UP;
            end else if (is_rev) begin
                step <= 1'b1;
                dir  <= DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (illegal) begin
            err       <= 1'b1;
            err_count <= clr_err ? ERR_W'(1) : sat_inc(err_count);
        end else if (clr_err) begin
            err       <= 1'b0;
            err_count <= '0;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with a step scoreboard checked by a
// free-running monitor on the falling clock edge.
module tb_quad_step_decoder;

    localparam int SYNC = 2;
    localparam int FLEN = 4;
    localparam int LAT  = SYNC + FLEN + 1;

    logic       clk = 1'b0;
    logic       reset, enc_a, enc_b, clr_err;
    logic       step, dir, err;
    logic [7:0] err_count;

    quad_step_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr_err(clr_err),
        .step(step), .dir(dir), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic dir;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic last_step = 1'b0;

    always @(negedge clk) begin
        if (step === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL step_unexpected: got step at cycle %0d dir=%0b, required no step", cyc, dir);
            end else begin
                mon_e = sb.pop_front();
                if (dir !== mon_e.dir || cyc != mon_e.cyc || last_step) begin
                    failures++;
                    $display("FAIL step_event: got dir=%0b cycle=%0d back_to_back=%0b, required dir=%0b cycle=%0d back_to_back=0",
                             dir, cyc, last_step, mon_e.dir, mon_e.cyc);
                end
            end
        end
        last_step = step;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d missing steps required 0", name, sb.size());
        end
        sb.delete();
    endtask

    // Change pins just after an edge and hold them for 'hold' edges.
    task automatic move(input logic a, input logic b, input logic exp_step,
                        input logic exp_dir, input int hold);
        @(posedge clk);
        #1;
        enc_a = a;
        enc_b = b;
        if (exp_step) sb.push_back('{exp_dir, cyc + LAT});
        repeat (hold - 1) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    logic seen_high;

    initial begin
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_step", step, 0);
        check("reset_dir", dir, 0);
        check("reset_err", err, 0);
        check("reset_err_count", err_count, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(posedge clk);

        // 1: forward rotation from 00
        move(0, 1, 1, 1'b0, 20);
        move(1, 1, 1, 1'b0, 20);
        move(1, 0, 1, 1'b0, 20);
        move(0, 0, 1, 1'b0, 20);
        @(negedge clk);
        drained("fwd_steps");
        check("fwd_dir", dir, 0);

        // 2: reverse rotation
        move(1, 0, 1, 1'b1, 20);
        move(1, 1, 1, 1'b1, 20);
        move(0, 1, 1, 1'b1, 20);
        move(0, 0, 1, 1'b1, 20);
        @(negedge clk);
        drained("rev_steps");
        check("rev_dir", dir, 1);
        check("rev_err", err, 0);

        // 3: glitch shorter than the filter, then one exactly as long
        move(1, 0, 0, 1'b0, 3);
        move(0, 0, 0, 1'b0, 1);
        seen_high = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_high |= u_dut.u_filt_a.filtered;
        end
        check("pulse3_filt_a", seen_high, 0);
        drained("pulse3_no_step");
        move(1, 0, 1, 1'b1, 4);
        move(0, 0, 1, 1'b0, 20);
        @(negedge clk);
        drained("pulse4_steps");

        // 4: illegal jumps and saturation
        move(1, 1, 0, 1'b0, 20);
        @(negedge clk);
        check("jump_err", err, 1);
        check("jump_err_count", err_count, 1);
        for (int i = 1; i <= 255; i++) begin
            move((i % 2) == 0, (i % 2) == 0, 0, 1'b0, 8);
            if (i == 254) begin
                @(negedge clk);
                check("sat_reach_255", err_count, 255);
            end
        end
        @(negedge clk);
        check("sat_hold_255", err_count, 255);
        check("sat_err", err, 1);
        drained("jumps_no_step");

        // 5: clear coinciding with an illegal jump, then clear alone
        move(1, 1, 0, 1'b0, LAT);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        check("clr_coincide_err", err, 1);
        check("clr_coincide_count", err_count, 1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        check("clr_alone_err", err, 0);
        check("clr_alone_count", err_count, 0);

        // 6: pins parked at 11 through reset release
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("init11_err", err, 0);
        check("init11_count", err_count, 0);
        drained("init11_no_step");
        move(1, 0, 1, 1'b0, 20);
        @(negedge clk);
        drained("init11_then_fwd");
        check("init11_fwd_dir", dir, 0);
        move(0, 1, 0, 1'b0, 20);
        @(negedge clk);
        check("pre_reset_err", err, 1);
        move(0, 0, 1, 1'b1, LAT);
        @(posedge clk);
        @(negedge clk);
        check("inflight_step", step, 1);
        #1 reset = 1'b1;
        #1;
        check("midreset_step", step, 0);
        check("midreset_dir", dir, 0);
        check("midreset_err", err, 0);
        check("midreset_count", err_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        drained("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
